// File: rtl/timer_pkg.sv
// Shared timekeeping definitions.
// Holds the default moduli for a 24-hour clock, the count-direction
// encoding used on every 'up' input, and a width helper for counters
// that must stay at least one bit wide.
package timer_pkg;

  localparam int DEF_SEC_MOD = 60;
  localparam int DEF_MIN_MOD = 60;
  localparam int DEF_HR_MOD  = 24;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Width needed to hold 0..v-1, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/mod_counter_stage.sv
// One modulo-MOD counting stage with up/down direction.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clear         synchronous zero
//   load          take load_val (caller has already range-checked it)
//   load_val      value to load
//   step          advance one position this cycle
//   up            DIR_UP counts up, DIR_DOWN counts down
//   value         registered count, always within [0, MOD-1]
//   wrap          combinational: this step passes the terminal value
module mod_counter_stage
  import timer_pkg::*;
#(
  parameter int MOD = DEF_SEC_MOD,
  parameter int W   = clog2_min1(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic         up,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  // Terminal value depends on the direction sampled this cycle.
  logic terminal;
  assign terminal = (up == DIR_UP) ? (value == LAST) : (value == '0);

  // A step that is overridden by reset, clear or load never wraps.
  assign wrap = step && terminal && !rst && !clear && !load;

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (step) begin
      if (up == DIR_UP) begin
        value <= terminal ? '0 : value + 1'b1;
      end else begin
        value <= terminal ? LAST : value - 1'b1;
      end
    end
  end

endmodule

// File: rtl/hms_counter.sv
// Hours/minutes/seconds counter built from three cascaded modulo stages.
// An enable prescaler produces one count tick every CLK_DIV enabled
// cycles; each stage's wrap strobe steps the next stage.
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   clear                      zero all stages and the prescaler
//   enable                     advance the prescaler
//   up                         DIR_UP / DIR_DOWN, sampled every cycle
//   load, load_sec/min/hr      all-or-nothing parallel load request
//   seconds, minutes, hours    registered counts
//   sec_wrap, min_wrap, day_wrap  combinational wrap strobes of the current tick
//   load_err                   registered one-cycle pulse for a rejected load
module hms_counter
  import timer_pkg::*;
#(
  parameter int SEC_MOD = DEF_SEC_MOD,
  parameter int MIN_MOD = DEF_MIN_MOD,
  parameter int HR_MOD  = DEF_HR_MOD,
  parameter int CLK_DIV = 1,
  localparam int SW = $clog2(SEC_MOD),
  localparam int MW = $clog2(MIN_MOD),
  localparam int HW = $clog2(HR_MOD),
  localparam int DW = clog2_min1(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic          up,
  input  logic          load,
  input  logic [SW-1:0] load_sec,
  input  logic [MW-1:0] load_min,
  input  logic [HW-1:0] load_hr,
  output logic [SW-1:0] seconds,
  output logic [MW-1:0] minutes,
  output logic [HW-1:0] hours,
  output logic          sec_wrap,
  output logic          min_wrap,
  output logic          day_wrap,
  output logic          load_err
);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  // One extra bit so a modulus that is an exact power of two still compares.
  localparam logic [SW:0]   SEC_LIM  = (SW + 1)'(SEC_MOD);
  localparam logic [MW:0]   MIN_LIM  = (MW + 1)'(MIN_MOD);
  localparam logic [HW:0]   HR_LIM   = (HW + 1)'(HR_MOD);

  logic [DW-1:0] div_cnt;
  logic          load_in_range;
  logic          load_ok;
  logic          tick;

  assign load_in_range = ({1'b0, load_sec} < SEC_LIM) &&
                         ({1'b0, load_min} < MIN_LIM) &&
                         ({1'b0, load_hr}  < HR_LIM);
  assign load_ok = load && load_in_range;

  // Any higher-priority action in the same cycle swallows the tick.
  assign tick = enable && (div_cnt == DIV_LAST) && !rst && !clear && !load;

  // Prescaler and load error flag. A rejected load leaves the prescaler alone.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      div_cnt  <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      if (load_ok) begin
        div_cnt <= '0;
      end
      load_err <= !load_in_range;
    end else begin
      load_err <= 1'b0;
      if (enable) begin
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      end
    end
  end

  mod_counter_stage #(.MOD(SEC_MOD), .W(SW)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (load_ok),
    .load_val (load_sec),
    .step     (tick),
    .up       (up),
    .value    (seconds),
    .wrap     (sec_wrap)
  );

  mod_counter_stage #(.MOD(MIN_MOD), .W(MW)) u_min (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (load_ok),
    .load_val (load_min),
    .step     (sec_wrap),
    .up       (up),
    .value    (minutes),
    .wrap     (min_wrap)
  );

  mod_counter_stage #(.MOD(HR_MOD), .W(HW)) u_hr (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .load     (load_ok),
    .load_val (load_hr),
    .step     (min_wrap),
    .up       (up),
    .value    (hours),
    .wrap     (day_wrap)
  );

endmodule

// File: tb/tb_hms_counter.sv
// Bench for hms_counter: three instances (default 60/60/24 with CLK_DIV=1,
// default moduli with CLK_DIV=4, and 10/6/2 with CLK_DIV=1) share the
// control inputs; each scenario selects one instance and checks it against
// a total-seconds reference model plus hand-computed literal values.
module tb_hms_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] ld_s = '0;
  logic [7:0] ld_m = '0;
  logic [7:0] ld_h = '0;

  always #5 clk = ~clk;

  logic [5:0] a_sec, a_min, p_sec, p_min;
  logic [4:0] a_hr, p_hr;
  logic [3:0] c_sec;
  logic [2:0] c_min;
  logic [0:0] c_hr;
  logic a_sw, a_mw, a_dw, a_err;
  logic p_sw, p_mw, p_dw, p_err;
  logic c_sw, c_mw, c_dw, c_err;

  hms_counter #(.CLK_DIV(1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_sec(ld_s[5:0]), .load_min(ld_m[5:0]), .load_hr(ld_h[4:0]),
    .seconds(a_sec), .minutes(a_min), .hours(a_hr),
    .sec_wrap(a_sw), .min_wrap(a_mw), .day_wrap(a_dw), .load_err(a_err)
  );

  hms_counter #(.CLK_DIV(4)) dut_p (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_sec(ld_s[5:0]), .load_min(ld_m[5:0]), .load_hr(ld_h[4:0]),
    .seconds(p_sec), .minutes(p_min), .hours(p_hr),
    .sec_wrap(p_sw), .min_wrap(p_mw), .day_wrap(p_dw), .load_err(p_err)
  );

  hms_counter #(.SEC_MOD(10), .MIN_MOD(6), .HR_MOD(2), .CLK_DIV(1)) dut_c (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_sec(ld_s[3:0]), .load_min(ld_m[2:0]), .load_hr(ld_h[0:0]),
    .seconds(c_sec), .minutes(c_min), .hours(c_hr),
    .sec_wrap(c_sw), .min_wrap(c_mw), .day_wrap(c_dw), .load_err(c_err)
  );

  // Observed outputs of the selected instance, zero-extended.
  int         sel = 0;
  logic [7:0] obs_s, obs_m, obs_h;
  logic [2:0] obs_w;
  logic       obs_err;

  always_comb begin
    obs_s = '0; obs_m = '0; obs_h = '0; obs_w = '0; obs_err = 1'b0;
    case (sel)
      0: begin
        obs_s = {2'b0, a_sec}; obs_m = {2'b0, a_min}; obs_h = {3'b0, a_hr};
        obs_w = {a_dw, a_mw, a_sw}; obs_err = a_err;
      end
      1: begin
        obs_s = {2'b0, p_sec}; obs_m = {2'b0, p_min}; obs_h = {3'b0, p_hr};
        obs_w = {p_dw, p_mw, p_sw}; obs_err = p_err;
      end
      default: begin
        obs_s = {4'b0, c_sec}; obs_m = {5'b0, c_min}; obs_h = {7'b0, c_hr};
        obs_w = {c_dw, c_mw, c_sw}; obs_err = c_err;
      end
    endcase
  end

  // Reference model state and parameters of the selected instance.
  int ms_mod, mm_mod, mh_mod, md, msw, mmw, mhw;
  int m_s, m_m, m_h, m_div;
  bit m_err;

  logic [31:0] exp_q[$];
  logic [2:0]  last_w;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic select_dut(input int d);
    sel = d;
    if (d == 2) begin
      ms_mod = 10; mm_mod = 6; mh_mod = 2; md = 1; msw = 4; mmw = 3; mhw = 1;
    end else begin
      ms_mod = 60; mm_mod = 60; mh_mod = 24; md = (d == 1) ? 4 : 1;
      msw = 6; mmw = 6; mhw = 5;
    end
  endtask

  // Drive one cycle of inputs, check the same-cycle wrap strobes, push the
  // expected post-edge state, then pop and compare it after the edge.
  task automatic cycle(input logic r, input logic c, input logic e, input logic u,
                       input logic l, input logic [7:0] ls, input logic [7:0] lm,
                       input logic [7:0] lh);
    bit tick, sw, mw, dw;
    int vs, vm, vh;
    logic [31:0] exp_v, got_v;
    rst = r; clear = c; enable = e; up = u; load = l;
    ld_s = ls; ld_m = lm; ld_h = lh;
    #1;
    tick = !r && !c && !l && e && (m_div == md - 1);
    sw = tick && (u ? (m_s == ms_mod - 1) : (m_s == 0));
    mw = sw && (u ? (m_m == mm_mod - 1) : (m_m == 0));
    dw = mw && (u ? (m_h == mh_mod - 1) : (m_h == 0));
    n_tests++;
    if (obs_w !== {dw, mw, sw}) begin
      n_fail++;
      $display("FAIL wraps t=%0t got %b expected %b", $time, obs_w, {dw, mw, sw});
    end
    last_w = obs_w;
    vs = int'(ls) & ((1 << msw) - 1);
    vm = int'(lm) & ((1 << mmw) - 1);
    vh = int'(lh) & ((1 << mhw) - 1);
    if (r || c) begin
      m_s = 0; m_m = 0; m_h = 0; m_div = 0; m_err = 0;
    end else if (l) begin
      if (vs < ms_mod && vm < mm_mod && vh < mh_mod) begin
        m_s = vs; m_m = vm; m_h = vh; m_div = 0; m_err = 0;
      end else begin
        m_err = 1;
      end
    end else begin
      m_err = 0;
      if (e) m_div = (m_div == md - 1) ? 0 : m_div + 1;
      if (tick) begin
        // Total-seconds arithmetic, independent of the stage structure.
        int n, t;
        n = ms_mod * mm_mod * mh_mod;
        t = (m_h * mm_mod + m_m) * ms_mod + m_s;
        t = u ? (t + 1) % n : (t + n - 1) % n;
        m_s = t % ms_mod;
        m_m = (t / ms_mod) % mm_mod;
        m_h = t / (ms_mod * mm_mod);
      end
    end
    exp_q.push_back({7'b0, m_err, 8'(m_h), 8'(m_m), 8'(m_s)});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    got_v = {7'b0, obs_err, obs_h, obs_m, obs_s};
    n_tests++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL state t=%0t got err/h/m/s=%h expected %h", $time, got_v, exp_v);
    end
  endtask

  task automatic idle(input logic e, input logic u);
    cycle(1'b0, 1'b0, e, u, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic do_load(input int h, input int m, input int s, input logic e);
    cycle(1'b0, 1'b0, e, 1'b1, 1'b1, 8'(s), 8'(m), 8'(h));
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic test_reset();
    select_dut(0);
    do_reset();
    n_tests++;
    if ({obs_h, obs_m, obs_s, obs_err, last_w} !== '0) begin
      n_fail++;
      $display("FAIL reset_state got %0d:%0d:%0d err=%b w=%b expected all 0",
               obs_h, obs_m, obs_s, obs_err, last_w);
    end
    do_load(12, 34, 56, 1'b0);
    n_tests++;
    if ({obs_h, obs_m, obs_s} !== {8'd12, 8'd34, 8'd56}) begin
      n_fail++;
      $display("FAIL load_12_34_56 got %0d:%0d:%0d", obs_h, obs_m, obs_s);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    n_tests++;
    if ({obs_h, obs_m, obs_s, obs_err} !== '0) begin
      n_fail++;
      $display("FAIL clear got %0d:%0d:%0d err=%b expected 0:0:0 err=0",
               obs_h, obs_m, obs_s, obs_err);
    end
  endtask

  task automatic test_up_chain();
    select_dut(0);
    do_load(23, 59, 58, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    n_tests++;
    if (last_w !== 3'b111 || {obs_h, obs_m, obs_s} !== '0) begin
      n_fail++;
      $display("FAIL up_rollover got w=%b %0d:%0d:%0d expected 111 0:0:0",
               last_w, obs_h, obs_m, obs_s);
    end
    idle(1'b1, 1'b1);
    n_tests++;
    if ({obs_h, obs_m, obs_s} !== {8'd0, 8'd0, 8'd1}) begin
      n_fail++;
      $display("FAIL up_after got %0d:%0d:%0d expected 0:0:1", obs_h, obs_m, obs_s);
    end
  endtask

  task automatic test_down_borrow();
    select_dut(0);
    do_load(0, 0, 1, 1'b0);
    idle(1'b1, 1'b0);
    n_tests++;
    if (last_w !== 3'b000 || {obs_h, obs_m, obs_s} !== '0) begin
      n_fail++;
      $display("FAIL down_first got w=%b %0d:%0d:%0d", last_w, obs_h, obs_m, obs_s);
    end
    idle(1'b1, 1'b0);
    n_tests++;
    if (last_w !== 3'b111 || {obs_h, obs_m, obs_s} !== {8'd23, 8'd59, 8'd59}) begin
      n_fail++;
      $display("FAIL down_borrow got w=%b %0d:%0d:%0d expected 111 23:59:59",
               last_w, obs_h, obs_m, obs_s);
    end
  endtask

  task automatic test_prescaler();
    select_dut(1);
    do_reset();
    for (int i = 0; i < 8; i++) idle(1'b1, 1'b1);
    n_tests++;
    if (obs_s !== 8'd2) begin
      n_fail++;
      $display("FAIL prescale_8 got sec=%0d expected 2", obs_s);
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0, 1'b1);
    n_tests++;
    if (obs_s !== 8'd2) begin
      n_fail++;
      $display("FAIL prescale_hold got sec=%0d expected 2", obs_s);
    end
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    n_tests++;
    if (obs_s !== 8'd3) begin
      n_fail++;
      $display("FAIL prescale_resume got sec=%0d expected 3", obs_s);
    end
    // Clear mid-prescale: the partial count is discarded.
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
    n_tests++;
    if (obs_s !== 8'd0) begin
      n_fail++;
      $display("FAIL prescale_clear got sec=%0d expected 0", obs_s);
    end
    idle(1'b1, 1'b1);
    n_tests++;
    if (obs_s !== 8'd1) begin
      n_fail++;
      $display("FAIL prescale_clear_tick got sec=%0d expected 1", obs_s);
    end
  endtask

  task automatic test_load_checks();
    select_dut(0);
    do_load(1, 2, 3, 1'b0);
    do_load(1, 2, 60, 1'b0);
    n_tests++;
    if (obs_err !== 1'b1 || {obs_h, obs_m, obs_s} !== {8'd1, 8'd2, 8'd3}) begin
      n_fail++;
      $display("FAIL load_reject got err=%b %0d:%0d:%0d expected 1 1:2:3",
               obs_err, obs_h, obs_m, obs_s);
    end
    idle(1'b0, 1'b1);
    n_tests++;
    if (obs_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_err_pulse got %b expected 0", obs_err);
    end
    do_load(1, 60, 3, 1'b0);
    do_load(24, 2, 3, 1'b0);
    do_load(23, 59, 59, 1'b1);
    do_load(5, 10, 20, 1'b1);
    n_tests++;
    if (last_w !== 3'b000 || {obs_h, obs_m, obs_s} !== {8'd5, 8'd10, 8'd20}) begin
      n_fail++;
      $display("FAIL load_with_tick got w=%b %0d:%0d:%0d expected 000 5:10:20",
               last_w, obs_h, obs_m, obs_s);
    end
  endtask

  task automatic test_custom_moduli();
    int day_cnt;
    select_dut(2);
    do_reset();
    day_cnt = 0;
    for (int i = 0; i < 120; i++) begin
      idle(1'b1, 1'b1);
      if (last_w[2]) day_cnt++;
    end
    n_tests++;
    if (day_cnt != 1 || {obs_h, obs_m, obs_s} !== '0) begin
      n_fail++;
      $display("FAIL custom_day got day_wraps=%0d %0d:%0d:%0d expected 1 0:0:0",
               day_cnt, obs_h, obs_m, obs_s);
    end
    for (int i = 0; i < 80; i++) begin
      idle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      n_tests++;
      if (obs_s >= 8'd10 || obs_m >= 8'd6 || obs_h >= 8'd2) begin
        n_fail++;
        $display("FAIL custom_range got %0d:%0d:%0d", obs_h, obs_m, obs_s);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    select_dut(0);
    do_load(23, 59, 50, 1'b0);
    for (int i = 0; i < 150; i++) begin
      int op;
      op = int'($urandom_range(0, 19));
      if (op == 0) begin
        do_load(int'($urandom_range(0, 25)), int'($urandom_range(0, 62)),
                int'($urandom_range(0, 62)), 1'($urandom_range(0, 1)));
      end else if (op == 1) begin
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      end else begin
        idle(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    select_dut(0);
    m_s = 0; m_m = 0; m_h = 0; m_div = 0; m_err = 0;
    last_w = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_up_chain();
    test_down_borrow();
    test_prescaler();
    test_load_checks();
    test_custom_moduli();
    test_back_to_back_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
